// File: rtl/stmt_lowerer_seq_deser.sv
// Serial-to-parallel deserializer with trailing parity check.
// One-entry output hold buffer on a valid/ready handshake.
module stmt_lowerer_seq_deser #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             msb_first,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        DATA,
        PARITY,
        FULL
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] shreg;
    logic             par;
    logic             ord;
    logic             beat;
    logic             msb_eff;
    logic [IW-1:0]    pos;
    logic             err_new;

    assign in_ready = rst_n && (state != FULL);
    assign beat     = in_valid && in_ready;
    // First beat of a frame uses the live order input, later beats the latch
    assign msb_eff  = (idx == '0) ? msb_first : ord;
    assign pos      = msb_eff ? (LAST - idx) : idx;
    assign err_new  = par ^ in_bit ^ PARITY_ODD;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DATA;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            DATA: begin
                if (flush) begin
                    state_nx = DATA;
                end else if (beat && idx == LAST) begin
                    state_nx = PARITY;
                end
            end
            PARITY: begin
                if (flush) begin
                    state_nx = DATA;
                end else if (beat) begin
                    state_nx = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_nx = DATA;
                end
            end
            default: state_nx = DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            ord       <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            unique case (state)
                DATA: begin
                    if (flush) begin
                        idx   <= '0;
                        par   <= 1'b0;
                        shreg <= '0;
                    end else if (beat) begin
                        shreg[pos] <= in_bit;
                        par        <= par ^ in_bit;
                        if (idx == '0) begin
                            ord <= msb_first;
                        end
                        if (idx != LAST) begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (flush) begin
                        idx   <= '0;
                        par   <= 1'b0;
                        shreg <= '0;
                    end else if (beat) begin
                        out_data  <= shreg;
                        out_err   <= err_new;
                        out_valid <= 1'b1;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        if (err_new && err_cnt != '1) begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                        idx   <= '0;
                        par   <= 1'b0;
                        shreg <= '0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stmt_lowerer_seq_deser.sv
// Randomized self-checking bench for stmt_lowerer_seq_deser (WIDTH=8, even parity).
// Expected words and counters come from a beat-list reference model.
module tb_stmt_lowerer_seq_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       msb_first;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_data;
    logic       exp_err;
    logic [7:0] mf;
    logic [7:0] me;

    always #5 clk = ~clk;

    stmt_lowerer_seq_deser #(
        .WIDTH(8),
        .PARITY_ODD(1'b0),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .msb_first(msb_first),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_err(out_err),
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt)
    );

    // Reference: beat i lands at position i (LSB-first) or 7-i (MSB-first);
    // even parity over data bits plus parity bit must be zero.
    task automatic model_frame(input logic [7:0] bits, input bit m0, input bit pb);
        logic [7:0] w;
        int ones;
        w = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (m0) w[7 - i] = bits[i];
            else    w[i] = bits[i];
            ones += int'(bits[i]);
        end
        ones += int'(pb);
        exp_data = w;
        exp_err  = (ones % 2) != 0;
        mf = 8'((int'(mf) + 1) % 256);
        if (exp_err && me != 8'd255) me = me + 8'd1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit b);
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bits, input bit m0, input bit mm,
                              input bit pb, input bit gaps, output bit vpre);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle();
            msb_first = (i == 0) ? m0 : mm;
            beat(bits[i]);
        end
        if (gaps && $urandom_range(0, 3) == 0) idle();
        in_valid = 1'b1;
        in_bit   = pb;
        vpre     = out_valid;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic hold_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        mf = '0;
        me = '0;
    endtask

    task automatic test_reset();
        flush     = 1'b0;
        msb_first = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        hold_reset();
        idle();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        checks++;
        if (out_data !== 8'h00 || out_err !== 1'b0 || frame_cnt !== 8'h00 || err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals: data=%h err=%b fc=%h ec=%h required 00 0 00 00",
                     out_data, out_err, frame_cnt, err_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_lsb();
        bit vpre;
        send_frame(8'b0011_0101, 1'b0, 1'b0, 1'b0, 1'b0, vpre);
        model_frame(8'b0011_0101, 1'b0, 1'b0);
        checks++;
        if (vpre !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL lsb_latency: valid before=%b after=%b required 0 1", vpre, out_valid);
        end
        checks++;
        if (out_data !== 8'h35 || out_data !== exp_data || out_err !== 1'b0) begin
            errors++;
            $display("FAIL lsb_word: data=%h err=%b required 35 0", out_data, out_err);
        end
        checks++;
        if (frame_cnt !== 8'd1 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL lsb_cnt: fc=%0d ec=%0d required 1 0", frame_cnt, err_cnt);
        end
        consume();
    endtask

    task automatic test_msb();
        bit vpre;
        send_frame(8'b0011_0101, 1'b1, 1'b0, 1'b0, 1'b0, vpre);
        model_frame(8'b0011_0101, 1'b1, 1'b0);
        checks++;
        if (out_data !== 8'hAC || out_data !== exp_data || out_err !== 1'b0) begin
            errors++;
            $display("FAIL msb_word: data=%h err=%b required ac 0", out_data, out_err);
        end
        consume();
    endtask

    task automatic test_err_sat();
        bit vpre;
        logic [7:0] b;
        hold_reset();
        rst_n = 1'b1;
        send_frame(8'b0011_0101, 1'b0, 1'b0, 1'b1, 1'b0, vpre);
        model_frame(8'b0011_0101, 1'b0, 1'b1);
        checks++;
        if (out_err !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL bad_parity: err=%b ec=%0d required 1 1", out_err, err_cnt);
        end
        consume();
        for (int f = 0; f < 260; f++) begin
            b = 8'($urandom);
            // choose the parity bit so every frame is an error
            send_frame(b, 1'($urandom), 1'($urandom), ~(^b), 1'b0, vpre);
            model_frame(b, 1'b0, ~(^b));
            consume();
        end
        checks++;
        if (err_cnt !== 8'd255 || err_cnt !== me) begin
            errors++;
            $display("FAIL err_sat: ec=%0d required 255", err_cnt);
        end
        checks++;
        if (frame_cnt !== 8'd5 || frame_cnt !== mf) begin
            errors++;
            $display("FAIL frame_wrap: fc=%0d required 5", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit vpre;
        logic [7:0] b;
        b = 8'($urandom);
        send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0, vpre);
        model_frame(b, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            flush = (c == 2);
            idle();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_data
                || out_err !== exp_err) begin
                errors++;
                $display("FAIL hold_c%0d: rdy=%b vld=%b data=%h err=%b required 0 1 %h %b",
                         c, in_ready, out_valid, out_data, out_err, exp_data, exp_err);
            end
        end
        flush = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        bit vpre;
        logic [7:0] b;
        logic [7:0] fc0;
        fc0 = frame_cnt;
        beat(1'b1);
        beat(1'b1);
        beat(1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        b = 8'($urandom);
        send_frame(b, 1'b0, 1'b0, ^b, 1'b0, vpre);
        model_frame(b, 1'b0, ^b);
        checks++;
        if (out_data !== exp_data || out_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_word: data=%h err=%b required %h 0", out_data, out_err, exp_data);
        end
        checks++;
        if (frame_cnt !== fc0 + 8'd1) begin
            errors++;
            $display("FAIL flush_cnt: fc=%0d required %0d", frame_cnt, fc0 + 8'd1);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        bit vpre;
        logic [7:0] b;
        for (int i = 0; i < 5; i++) beat(1'($urandom));
        hold_reset();
        checks++;
        if (out_valid !== 1'b0 || frame_cnt !== 8'd0 || err_cnt !== 8'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: vld=%b fc=%0d ec=%0d rdy=%b required 0 0 0 0",
                     out_valid, frame_cnt, err_cnt, in_ready);
        end
        rst_n = 1'b1;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, vpre);
        hold_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0
            || frame_cnt !== 8'd0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_full: vld=%b data=%h err=%b fc=%0d ec=%0d required 0 00 0 0 0",
                     out_valid, out_data, out_err, frame_cnt, err_cnt);
        end
        rst_n = 1'b1;
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b1, 1'b0, 1'b0, vpre);
        model_frame(b, 1'b1, 1'b0);
        checks++;
        if (out_data !== exp_data || out_err !== exp_err || frame_cnt !== mf || err_cnt !== me) begin
            errors++;
            $display("FAIL rst_after: data=%h err=%b fc=%0d ec=%0d required %h %b %0d %0d",
                     out_data, out_err, frame_cnt, err_cnt, exp_data, exp_err, mf, me);
        end
        consume();
    endtask

    task automatic test_random();
        bit vpre;
        bit m0;
        bit pb;
        logic [7:0] b;
        for (int f = 0; f < 30; f++) begin
            b  = 8'($urandom);
            m0 = 1'($urandom);
            pb = 1'($urandom);
            send_frame(b, m0, 1'($urandom), pb, 1'b1, vpre);
            model_frame(b, m0, pb);
            checks++;
            if (vpre !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_data
                || out_err !== exp_err || frame_cnt !== mf || err_cnt !== me) begin
                errors++;
                $display("FAIL rand_f%0d: v=%b/%b data=%h err=%b fc=%0d ec=%0d required 0/1 %h %b %0d %0d",
                         f, vpre, out_valid, out_data, out_err, frame_cnt, err_cnt,
                         exp_data, exp_err, mf, me);
            end
            for (int w = $urandom_range(0, 2); w > 0; w--) idle();
            consume();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        msb_first = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        mf        = '0;
        me        = '0;
        exp_data  = '0;
        exp_err   = 1'b0;
        test_reset();
        test_lsb();
        test_msb();
        test_err_sat();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stmt_lowerer_seq_deser.md
Name: stmt_lowerer_seq_deser

Overview:
- Sequential serial-to-parallel deserializer. It is the reader counterpart to the combinational indexed-LHS writers in the statement-lowering fixtures.
- Assembles a WIDTH-bit word one bit per accepted beat, writing each bit through a dynamic index (`shreg[idx] <=`) inside an always_ff.
- Checks a trailing parity bit and presents the word on a valid/ready output with a 1-entry hold buffer.
- Serves as the sequential-lowering fixture: FSM `case`, dynamic-index nonblocking LHS writes, and saturating counters.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..64.
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.
- CNT_W, 8, width of the frame and error counters.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous discard of any partially assembled frame.
- msb_first  input  1  bit order; sampled only on the first data beat of a frame.
- in_valid  input  1  serial beat valid.
- in_bit  input  1  serial data or parity bit.
- in_ready  output  1  deserializer can accept a beat.
- out_valid  output  1  assembled word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  assembled word.
- out_err  output  1  parity mismatch for the word on out_data.
- frame_cnt  output  CNT_W  frames completed; wraps.
- err_cnt  output  CNT_W  parity errors; saturates at all-ones.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=DATA, bit counter idx=0, shreg=0, running parity=0, order latch=0, out_data=0, out_err=0, out_valid=0, frame_cnt=0, err_cnt=0.
- in_ready: 0 while rst_n=0; otherwise 1 in every state except FULL.
- Beat definition: a beat is accepted when in_valid && in_ready at the clock edge.

States:
- DATA:
  - On each accepted beat, write in_bit to shreg[idx] if the order is LSB-first, else to shreg[WIDTH-1-idx].
  - Update the running parity: par <= par ^ in_bit.
  - On the beat with idx==0, latch msb_first; that beat's own bit uses the new msb_first value.
  - If idx==WIDTH-1, go to PARITY; otherwise idx <= idx+1.
- PARITY:
  - The accepted beat is the parity bit.
  - out_data <= shreg; out_err <= par ^ in_bit ^ PARITY_ODD.
  - frame_cnt <= frame_cnt+1 (wraps).
  - If out_err is set, err_cnt increments, saturating at all-ones.
  - out_valid <= 1; go to FULL.
  - Clear idx, par and shreg.
- FULL:
  - out_valid=1; out_data and out_err are held stable.
  - On out_valid && out_ready: out_valid <= 0, go to DATA.
  - The first beat of the next frame can be accepted on the following cycle.

Latency and throughput:
- out_valid rises on the cycle after the parity beat is accepted.
- Minimum frame period is WIDTH+2 cycles: WIDTH data beats, 1 parity beat, 1 FULL cycle.

Flush:
- In DATA or PARITY: flush=1 returns to DATA with idx, par and shreg cleared.
- A beat accepted in the same cycle as flush is discarded; flush wins.
- No counter changes on flush.
- In FULL: flush has no effect; the held word is preserved.

Priority and boundaries:
- Priority order: rst_n > flush > beat / handshake.
- in_valid=0 mid-frame: state is held indefinitely.
- rst_n low mid-frame or in FULL: everything returns to reset values on that edge and the held word is lost.
- idx is sized as clog2(WIDTH), never exceeds WIDTH-1, and has no wrap path.
- err_cnt at all-ones with a new error: stays at all-ones.
- frame_cnt at all-ones: wraps to 0.

Test Plan:
- WIDTH=8, LSB-first, beats 1,0,1,0,1,1,0,0, parity 0 -> out_data=0x35, out_err=0, out_valid high exactly 1 cycle after the parity beat, frame_cnt=1, err_cnt=0.
- Same bits with msb_first=1 on the first beat, toggled to 0 mid-frame -> out_data=0xAC (order latched at frame start), out_err=0.
- Frame 0x35 with parity bit 1 -> out_err=1, err_cnt=1. Then 260 bad-parity frames -> err_cnt=255, frame_cnt=261 mod 256=5.
- Complete a frame while holding out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_data stable throughout. Raise out_ready -> out_valid drops next cycle and in_ready=1 that same cycle.
- Send 3 bits, then flush=1 with in_valid=1 -> that beat is dropped. The following 8 data beats plus parity form a clean frame, frame_cnt increments by 1 only.
- rst_n=0 for 1 cycle after 5 data bits, and separately while in FULL -> all outputs return to reset values. A subsequent full frame decodes correctly.
